// File: rtl/tpu_start_sequencer_if.sv
// Button/TPU handshake bundle between the start sequencer (master) and its board-level neighbours.
interface tpu_start_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             btn_start;
  logic             tpu_done;
  logic             tpu_start;
  logic             busy;
  logic             done_pulse;
  logic             timeout;
  logic [CNT_W-1:0] run_cycles;

  modport master (
    input  btn_start, tpu_done,
    output tpu_start, busy, done_pulse, timeout, run_cycles
  );

  modport slave (
    output btn_start, tpu_done,
    input  tpu_start, busy, done_pulse, timeout, run_cycles
  );
endinterface

// File: rtl/tpu_start_sequencer.sv
// Debounces BTN1, issues one tpu_start strobe per press, then times the TPU run until tpu_done or timeout.
module tpu_start_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int CNT_W           = 32
) (
  input logic                   clk,
  input logic                   srstn,
  tpu_start_sequencer_if.master bus
);
  localparam int               DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, WAIT_REL} state_t;

  state_t           state;
  logic             sync1, sync2;
  logic             deb_level, deb_level_d;
  logic [DB_W-1:0]  deb_cnt;
  logic             press_evt;
  logic [CNT_W-1:0] run_cnt;
  logic             tpu_start_r, busy_r, done_pulse_r, timeout_r;
  logic [CNT_W-1:0] run_cycles_r;

  // deb_cnt counts consecutive synced samples that disagree with the debounced level;
  // any agreeing sample (a bounce back) restarts the count.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync1       <= bus.btn_start;
      sync2       <= sync1;
      deb_level_d <= deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press_evt = deb_level & ~deb_level_d;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state        <= IDLE;
      run_cnt      <= '0;
      tpu_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      timeout_r    <= 1'b0;
      run_cycles_r <= '0;
    end else begin
      tpu_start_r  <= 1'b0;
      done_pulse_r <= 1'b0;
      case (state)
        IDLE: begin
          if (press_evt) begin
            state       <= START;
            tpu_start_r <= 1'b1;
            busy_r      <= 1'b1;
            timeout_r   <= 1'b0;
            run_cnt     <= '0;
          end
        end
        START: state <= RUN;
        RUN: begin
          // Completion is checked before the timeout so a done on the last allowed cycle still succeeds.
          if (bus.tpu_done) begin
            run_cycles_r <= run_cnt;
            done_pulse_r <= 1'b1;
            busy_r       <= 1'b0;
            state        <= WAIT_REL;
          end else if (run_cnt == TO_LAST) begin
            run_cycles_r <= run_cnt;
            timeout_r    <= 1'b1;
            busy_r       <= 1'b0;
            state        <= WAIT_REL;
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!deb_level) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tpu_start  = tpu_start_r;
  assign bus.busy       = busy_r;
  assign bus.done_pulse = done_pulse_r;
  assign bus.timeout    = timeout_r;
  assign bus.run_cycles = run_cycles_r;
endmodule

// File: tb/tb_tpu_start_sequencer.sv
// Randomized self-checking bench for tpu_start_sequencer against an outcome-level run model.
module tb_tpu_start_sequencer;
  localparam int DEB   = 4;
  localparam int TOUT  = 20;
  localparam int CNT_W = 32;
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic clk;
  logic srstn;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   both_high = 0;

  tpu_start_sequencer_if #(.CNT_W(CNT_W)) bus ();

  tpu_start_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tpu_start) start_cnt++;
    if (bus.tpu_start && bus.done_pulse) both_high++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic b, input int n);
    bus.btn_start = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.tpu_start) found = 1'b1;
    end
  endtask

  // Model: tpu_done driven in cycle d after the start cycle succeeds iff d <= TOUT with
  // run_cycles = d-1; otherwise the run fails after TOUT cycles with run_cycles = TOUT-1.
  task automatic do_run(input int d, input int mode, input int extra_hold);
    bit ok;
    bit found;
    int lat, exp_rc, exp_edge, base, busy_bad;
    ok       = (d <= TOUT);
    exp_rc   = ok ? d - 1 : TOUT - 1;
    exp_edge = ok ? d + 1 : TOUT + 1;
    base     = start_cnt;
    busy_bad = 0;
    bus.btn_start = 1'b1;
    wait_start(found, lat);
    checkOutput("start_seen", found, 1);
    if (!found) begin
      bus.btn_start = 1'b0;
      return;
    end
    checkOutput("start_lat", lat, PRESS_LAT);
    checkOutput("tout_clr", bus.timeout, 0);
    checkOutput("busy_start", bus.busy, 1);
    bus.tpu_done = 1'b0;
    for (int k = 1; k <= exp_edge + 1; k++) begin
      @(negedge clk);
      if (k < exp_edge && !bus.busy) busy_bad++;
      if (k == exp_edge) begin
        checkOutput("done_pulse", bus.done_pulse, ok);
        checkOutput("timeout", bus.timeout, !ok);
        checkOutput("run_cycles", bus.run_cycles, exp_rc);
        checkOutput("busy_end", bus.busy, 0);
      end
      if (k == exp_edge + 1) checkOutput("done_1cyc", bus.done_pulse, 0);
      bus.tpu_done = (k == d);
      case (mode)
        0:       bus.btn_start = 1'b1;
        1:       bus.btn_start = (k + 8 <= exp_edge) && ((k % 12) >= 6);
        default: bus.btn_start = (k + 8 <= exp_edge) && ($urandom_range(0, 1) == 1);
      endcase
    end
    bus.tpu_done = 1'b0;
    checkOutput("busy_run", busy_bad, 0);
    if (mode == 0) applyStimulus(1'b1, extra_hold);
    applyStimulus(1'b0, 15);
    checkOutput("one_start", start_cnt - base, 1);
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("tout_sticky", bus.timeout, !ok);
  endtask

  // Bounce runs are at most DEB-1 samples long, so no debounced edge may appear.
  task automatic do_random_bounce(input int runs);
    int base;
    base = start_cnt;
    for (int i = 0; i < runs; i++) begin
      applyStimulus(1'b1, $urandom_range(1, DEB - 1));
      applyStimulus(1'b0, $urandom_range(1, DEB - 1));
    end
    applyStimulus(1'b0, 15);
    checkOutput("bounce_rand", start_cnt - base, 0);
  endtask

  task automatic do_reset_midrun();
    bit found;
    int lat, base, idle_bad;
    bus.btn_start = 1'b1;
    wait_start(found, lat);
    checkOutput("rst_start_seen", found, 1);
    bus.btn_start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_busy_before", bus.busy, 1);
    srstn = 1'b0;
    #1;
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_start", bus.tpu_start, 0);
    checkOutput("rst_done", bus.done_pulse, 0);
    checkOutput("rst_tout", bus.timeout, 0);
    checkOutput("rst_rc", bus.run_cycles, 0);
    @(negedge clk);
    srstn        = 1'b1;
    bus.tpu_done = 1'b1;
    base         = start_cnt;
    idle_bad     = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) bus.tpu_done = 1'b0;
      if (bus.done_pulse || bus.busy || bus.timeout) idle_bad++;
    end
    checkOutput("rst_idle", idle_bad, 0);
    checkOutput("rst_nostart", start_cnt - base, 0);
  endtask

  initial begin
    int base;
    bus.btn_start = 1'b0;
    bus.tpu_done  = 1'b0;
    srstn         = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_start", bus.tpu_start, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done_pulse, 0);
    checkOutput("reset_tout", bus.timeout, 0);
    checkOutput("reset_rc", bus.run_cycles, 0);
    srstn = 1'b1;
    repeat (5) @(negedge clk);

    do_run(7, 1, 0);

    base = start_cnt;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 15);
    checkOutput("bounce_fixed", start_cnt - base, 0);

    do_run(1000, 1, 0);
    do_run(9, 1, 0);
    do_run(18, 1, 0);
    do_run(10, 0, 100);
    do_run(TOUT, 1, 0);
    do_run(TOUT + 1, 2, 0);
    do_run(1, 0, 5);

    do_reset_midrun();
    do_run(5, 1, 0);

    for (int i = 0; i < 12; i++) begin
      do_random_bounce($urandom_range(1, 5));
      do_run($urandom_range(1, TOUT + 5), $urandom_range(0, 2), $urandom_range(5, 40));
    end

    checkOutput("start_done_excl", both_high, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
